// File: rtl/bp_seq_pkg.sv
// Shared types for the backprop sequencer: FSM state encoding and index width.
package bp_seq_pkg;

  localparam int IDX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    PROP,
    COPY,
    DRAIN,
    DONE
  } bp_seq_state_t;

endpackage

// File: rtl/bp_beat_counter.sv
// Modulo-SIZE counter with enable and sync clear; terminal marks the last count value.
module bp_beat_counter
  import bp_seq_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == IDX_W'(SIZE - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/backprop_sequencer.sv
// Sequences one backprop_stack through a full backward pass: per-layer fill
// (clear, accumulate rows, propagate) followed by per-layer drain of dc_dw rows.
module backprop_sequencer
  import bp_seq_pkg::*;
#(
  parameter int SIZE           = 3,
  parameter int MAX_LAYER_SIZE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] num_layers,
  input  logic             row_valid,
  output logic             row_ready,
  output logic             stack_clear,
  output logic             stack_copy,
  output logic             stack_cal_dy_dy_old,
  output logic [IDX_W-1:0] current_layer_index,
  output logic [IDX_W-1:0] dc_dw_layer_index,
  output logic             dc_dw_valid,
  output logic             dc_dw_last,
  output logic             busy,
  output logic             done,
  output logic             error
);

  bp_seq_state_t    state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic             error_q, error_d;
  logic             valid_q;
  logic             last_q, last_d;
  logic             beat_term, col_term;
  logic [IDX_W-1:0] unused_beat_count;
  logic [IDX_W-1:0] col_count;
  logic             last_layer;

  bp_beat_counter #(.SIZE(SIZE)) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q != ACCUM),
    .enable   ((state_q == ACCUM) && row_valid),
    .count    (unused_beat_count),
    .terminal (beat_term)
  );

  bp_beat_counter #(.SIZE(SIZE)) u_col_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q != DRAIN),
    .enable   (state_q == DRAIN),
    .count    (col_count),
    .terminal (col_term)
  );

  assign last_layer = (k_q == n_q - IDX_W'(1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    error_d = 1'b0;
    last_d  = (state_q == DRAIN) && col_term && last_layer;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((num_layers >= IDX_W'(1)) && (num_layers <= IDX_W'(MAX_LAYER_SIZE - 1))) begin
            n_d     = num_layers;
            k_d     = '0;
            state_d = CLEAR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = ACCUM;
      ACCUM: if (row_valid && beat_term) state_d = PROP;
      PROP: begin
        if (!last_layer) begin
          k_d     = k_q + IDX_W'(1);
          state_d = CLEAR;
        end else begin
          k_d     = '0;
          state_d = COPY;
        end
      end
      COPY: state_d = DRAIN;
      DRAIN: begin
        if (col_term) begin
          if (last_layer) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + IDX_W'(1);
            state_d = COPY;
          end
        end
      end
      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dc_dw_valid/last trail DRAIN by one cycle to line up with the stack's registered dc_dw.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      error_q <= error_d;
      valid_q <= (state_q == DRAIN);
      last_q  <= last_d;
    end
  end

  assign row_ready           = (state_q == ACCUM);
  assign stack_clear         = (state_q == CLEAR);
  assign stack_copy          = (state_q == COPY);
  assign stack_cal_dy_dy_old = (state_q == PROP);
  assign current_layer_index = k_q;
  assign dc_dw_layer_index   = (state_q == DRAIN) ? col_count : '0;
  assign dc_dw_valid         = valid_q;
  assign dc_dw_last          = last_q;
  assign busy                = (state_q != IDLE);
  assign done                = (state_q == DONE);
  assign error               = error_q;

endmodule

// File: tb/tb_backprop_sequencer.sv
// Scoreboard bench: a cycle-level pass model queues expected stack strobes and
// dc_dw rows; a negedge monitor pops and compares whenever the DUT shows one.
module tb_backprop_sequencer;

  localparam int SIZE     = 3;
  localparam int MAX_LAYR = 10;
  localparam int K_ERR    = 0;
  localparam int K_CLEAR  = 1;
  localparam int K_PROP   = 2;
  localparam int K_ROW    = 3;
  localparam int K_COPY   = 4;
  localparam int K_DONE   = 5;

  typedef struct {
    int kind;
    int layer;
    int col;
    bit last;
    int cyc;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] num_layers;
  logic        row_valid;
  logic        row_ready;
  logic        stack_clear;
  logic        stack_copy;
  logic        stack_cal_dy_dy_old;
  logic [31:0] current_layer_index;
  logic [31:0] dc_dw_layer_index;
  logic        dc_dw_valid;
  logic        dc_dw_last;
  logic        busy;
  logic        done;
  logic        error;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  base = 0;
  int  rel = 0;
  int  beats_seen = 0;
  int  beats_want = 0;
  int  last_done_rel = -1;
  int  prev_layer = 0;
  int  prev_col = 0;
  bit  pat[0:1023];
  ev_t exp_q[$];

  backprop_sequencer #(.SIZE(SIZE), .MAX_LAYER_SIZE(MAX_LAYR)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .num_layers          (num_layers),
    .row_valid           (row_valid),
    .row_ready           (row_ready),
    .stack_clear         (stack_clear),
    .stack_copy          (stack_copy),
    .stack_cal_dy_dy_old (stack_cal_dy_dy_old),
    .current_layer_index (current_layer_index),
    .dc_dw_layer_index   (dc_dw_layer_index),
    .dc_dw_valid         (dc_dw_valid),
    .dc_dw_last          (dc_dw_last),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void push(input int kind, input int layer, input int col, input bit last, input int cy);
    ev_t e;
    e.kind  = kind;
    e.layer = layer;
    e.col   = col;
    e.last  = last;
    e.cyc   = cy;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int kind, input int layer, input int col, input bit last);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got kind=%0d layer=%0d col=%0d at rel cycle %0d, want none",
               kind, layer, col, rel);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.layer != layer || e.col != col || e.last != last || e.cyc != rel) begin
        errors++;
        $display("[TB] FAIL event: got kind=%0d layer=%0d col=%0d last=%0b cyc=%0d, want kind=%0d layer=%0d col=%0d last=%0b cyc=%0d",
                 kind, layer, col, last, rel, e.kind, e.layer, e.col, e.last, e.cyc);
      end
    end
  endtask

  // Monitor: fixed observation order matches the order the model queues same-cycle events.
  always @(negedge clk) begin
    rel = cyc - base;
    if (row_valid && row_ready) beats_seen++;
    if (dc_dw_last && !dc_dw_valid) check_output("last_without_valid", 1, 0);
    if (error) observe(K_ERR, 0, 0, 1'b0);
    if (stack_clear) observe(K_CLEAR, int'(current_layer_index), 0, 1'b0);
    if (stack_cal_dy_dy_old) observe(K_PROP, int'(current_layer_index), 0, 1'b0);
    if (dc_dw_valid) observe(K_ROW, prev_layer, prev_col, dc_dw_last);
    if (stack_copy) observe(K_COPY, int'(current_layer_index), 0, 1'b0);
    if (done) begin
      observe(K_DONE, 0, 0, 1'b0);
      check_output("beat_count", beats_seen, beats_want);
      last_done_rel = rel;
    end
    prev_layer = int'(current_layer_index);
    prev_col   = int'(dc_dw_layer_index);
  end

  // Reference pass: cycle 1 is the first cycle after the accepting edge.
  task automatic model_pass(input int n, output int last_j);
    int j = 1;
    int b;
    for (int k = 0; k < n; k++) begin
      push(K_CLEAR, k, 0, 1'b0, j);
      j++;
      b = 0;
      while (b < SIZE) begin
        if (j >= 1024 || pat[j]) b++;
        j++;
      end
      push(K_PROP, k, 0, 1'b0, j);
      j++;
    end
    for (int k = 0; k < n; k++) begin
      push(K_COPY, k, 0, 1'b0, j);
      j++;
      for (int c = 0; c < SIZE; c++) begin
        push(K_ROW, k, c, (k == n - 1) && (c == SIZE - 1), j + 1);
        j++;
      end
    end
    push(K_DONE, 0, 0, 1'b0, j);
    last_j = j;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_row_ready"}, row_ready, 0);
    check_output({tag, "_stack_clear"}, stack_clear, 0);
    check_output({tag, "_stack_copy"}, stack_copy, 0);
    check_output({tag, "_stack_cal"}, stack_cal_dy_dy_old, 0);
    check_output({tag, "_cur_idx"}, current_layer_index, 0);
    check_output({tag, "_col_idx"}, dc_dw_layer_index, 0);
    check_output({tag, "_dc_dw_valid"}, dc_dw_valid, 0);
    check_output({tag, "_dc_dw_last"}, dc_dw_last, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_error"}, error, 0);
  endtask

  task automatic fill_pattern(input int mode);
    for (int i = 0; i < 1024; i++) pat[i] = (mode == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
  endtask

  task automatic apply_stimulus(input int n, input int reset_at, input int restart_at);
    int last_j;
    @(posedge clk); #1;
    base          = cyc;
    beats_seen    = 0;
    beats_want    = n * SIZE;
    last_done_rel = -1;
    model_pass(n, last_j);
    start      = 1'b1;
    num_layers = n;
    row_valid  = 1'b0;
    for (int j = 1; j <= last_j + 2; j++) begin
      @(posedge clk); #1;
      start      = (j == restart_at);
      num_layers = $urandom;
      row_valid  = (j < 1024) ? pat[j] : 1'b1;
      reset      = (j == reset_at);
      if (reset_at > 0 && j == reset_at + 1) begin
        exp_q.delete();
        check_idle("after_reset");
        break;
      end
    end
    start     = 1'b0;
    row_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("queue_drained", exp_q.size(), 0);
    check_idle("post_pass");
  endtask

  task automatic apply_reject(input logic [31:0] n);
    @(posedge clk); #1;
    base = cyc;
    push(K_ERR, 0, 0, 1'b0, 1);
    start      = 1'b1;
    num_layers = n;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("reject_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_output("reject_queue", exp_q.size(), 0);
    check_idle("reject_idle");
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want $finish before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    num_layers = '0;
    row_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    fill_pattern(0);
    apply_stimulus(2, 0, 0);
    check_output("t1_done_cycle", last_done_rel, 19);

    fill_pattern(0);
    for (int i = 3; i <= 6; i++) pat[i] = 1'b0;
    apply_stimulus(1, 0, 0);
    check_output("t2_done_cycle", last_done_rel, 14);

    apply_reject(32'd0);
    apply_reject(32'd10);
    apply_reject(32'hFFFF_FFFF);
    fill_pattern(0);
    apply_stimulus(9, 0, 0);
    check_output("max_layers_done_cycle", last_done_rel, 9 * (2 * SIZE + 3) + 1);

    fill_pattern(0);
    apply_stimulus(2, 16, 0);
    check_output("reset_no_done", last_done_rel, -1);

    fill_pattern(0);
    apply_stimulus(2, 0, 5);
    apply_stimulus(1, 0, 0);

    fill_pattern(0);
    apply_stimulus(3, 0, 0);

    // start and reset together: reset must win and nothing may follow
    @(posedge clk); #1;
    start      = 1'b1;
    reset      = 1'b1;
    num_layers = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    check_idle("start_vs_reset");
    repeat (2) @(posedge clk);
    #1;
    check_idle("start_vs_reset_later");

    for (int r = 0; r < 8; r++) begin
      fill_pattern(1);
      apply_stimulus($urandom_range(MAX_LAYR - 1, 1), 0, (r % 2 == 1) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
